// File: rtl/sq_distance.sv
// Squared Euclidean distance between two sphere centres using one shared float adder and one shared float multiplier.
// Optional output `coincident` is built only when SQ_DISTANCE_COINCIDENT_EN is defined.

module sq_distance_fp_core #(
    parameter bit IS_MUL = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] i_a,
    input  logic        i_a_stb,
    output logic        o_a_ack,
    input  logic [31:0] i_b,
    input  logic        i_b_stb,
    output logic        o_b_ack,
    output logic [31:0] o_z,
    output logic        o_z_stb,
    input  logic        i_z_ack
);
    typedef enum logic [1:0] {C_GET, C_CALC, C_PUT} core_state_t;

    core_state_t r_state;
    logic [31:0] r_a, r_b, r_z;
    logic        r_a_ack, r_b_ack, r_z_stb;

    // Subnormal inputs and results are flushed to signed zero; rounding is nearest-even.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s, g, st;
        logic [47:0]        ma, mb, prod;
        logic [23:0]        m;
        logic [24:0]        mr;
        logic signed [10:0] e;
        logic [31:0]        r;
        s = a[31] ^ b[31];
        r = 32'd0;
        if ((a[30:23] == 8'hFF) && (a[22:0] != 23'd0)) begin
            r = a;
        end else if ((b[30:23] == 8'hFF) && (b[22:0] != 23'd0)) begin
            r = b;
        end else if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) begin
            r = ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) ? 32'h7FC00000 : {s, 8'hFF, 23'd0};
        end else if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) begin
            r = {s, 31'd0};
        end else begin
            ma   = {24'd0, 1'b1, a[22:0]};
            mb   = {24'd0, 1'b1, b[22:0]};
            prod = ma * mb;
            e    = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
            if (prod[47]) begin
                m = prod[47:24]; g = prod[23]; st = |prod[22:0]; e = e + 11'sd1;
            end else begin
                m = prod[46:23]; g = prod[22]; st = |prod[21:0];
            end
            mr = {1'b0, m} + {24'd0, g & (st | m[0])};
            if (mr[24]) begin
                mr = {1'b0, mr[24:1]}; e = e + 11'sd1;
            end
            if (e >= 11'sd255)    r = {s, 8'hFF, 23'd0};
            else if (e <= 11'sd0) r = {s, 31'd0};
            else                  r = {s, e[7:0], mr[22:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y, r;
        logic [26:0]        mx, my, sh;
        logic [27:0]        sum;
        logic [7:0]         d;
        logic [4:0]         dd;
        logic [24:0]        mr;
        logic signed [10:0] e;
        r = 32'd0; x = a; y = b;
        if ((a[30:23] == 8'hFF) && (a[22:0] != 23'd0)) begin
            r = a;
        end else if ((b[30:23] == 8'hFF) && (b[22:0] != 23'd0)) begin
            r = b;
        end else if (a[30:23] == 8'hFF) begin
            r = ((b[30:23] == 8'hFF) && (a[31] != b[31])) ? 32'h7FC00000 : a;
        end else if (b[30:23] == 8'hFF) begin
            r = b;
        end else if ((a[30:23] == 8'd0) && (b[30:23] == 8'd0)) begin
            r = {a[31] & b[31], 31'd0};
        end else if (a[30:23] == 8'd0) begin
            r = b;
        end else if (b[30:23] == 8'd0) begin
            r = a;
        end else begin
            if (a[30:0] < b[30:0]) begin
                x = b; y = a;
            end
            d     = x[30:23] - y[30:23];
            dd    = (d > 8'd27) ? 5'd27 : d[4:0];
            mx    = {1'b1, x[22:0], 3'b000};
            my    = {1'b1, y[22:0], 3'b000};
            sh    = my >> dd;
            sh[0] = sh[0] | ((sh << dd) != my);
            e     = $signed({3'b000, x[30:23]});
            sum   = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, sh}) : ({1'b0, mx} - {1'b0, sh});
            if (sum != 28'd0) begin
                if (sum[27]) begin
                    sum = {1'b0, sum[27:2], sum[1] | sum[0]}; e = e + 11'sd1;
                end
                for (int i = 0; i < 26; i++) begin
                    if (!sum[26]) begin
                        sum = {sum[26:0], 1'b0}; e = e - 11'sd1;
                    end
                end
                mr = {1'b0, sum[26:3]} + {24'd0, sum[2] & ((|sum[1:0]) | sum[3])};
                if (mr[24]) begin
                    mr = {1'b0, mr[24:1]}; e = e + 11'sd1;
                end
                if (e >= 11'sd255)    r = {x[31], 8'hFF, 23'd0};
                else if (e <= 11'sd0) r = {x[31], 31'd0};
                else                  r = {x[31], e[7:0], mr[22:0]};
            end
        end
        return r;
    endfunction

    // Accept both operands, evaluate for one cycle, then hold the result until acknowledged.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= C_GET;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_z     <= 32'd0;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_z_stb <= 1'b0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                C_GET: begin
                    if (i_a_stb && i_b_stb) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_a_ack <= 1'b1;
                        r_b_ack <= 1'b1;
                        r_state <= C_CALC;
                    end else begin
                        r_state <= C_GET;
                    end
                end
                C_CALC: begin
                    r_z     <= IS_MUL ? fp_mul(r_a, r_b) : fp_add(r_a, r_b);
                    r_z_stb <= 1'b1;
                    r_state <= C_PUT;
                end
                C_PUT: begin
                    if (i_z_ack) begin
                        r_z_stb <= 1'b0;
                        r_state <= C_GET;
                    end else begin
                        r_state <= C_PUT;
                    end
                end
                default: begin
                    r_z_stb <= 1'b0;
                    r_state <= C_GET;
                end
            endcase
        end
    end

    assign o_a_ack = r_a_ack;
    assign o_b_ack = r_b_ack;
    assign o_z     = r_z;
    assign o_z_stb = r_z_stb;
endmodule

module sq_distance (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] p1x,
    input  logic [31:0] p1y,
    input  logic [31:0] p1z,
    input  logic [31:0] p2x,
    input  logic [31:0] p2y,
    input  logic [31:0] p2z,
    input  logic        in_stb,
    output logic        in_ack,
    output logic [31:0] dist_sq,
    output logic        out_stb,
    input  logic        out_ack,
    output logic        busy
`ifdef SQ_DISTANCE_COINCIDENT_EN
    ,
    output logic        coincident
`endif
);
    typedef enum logic [3:0] {IDLE, SUB_X, SUB_Y, SUB_Z, MUL_X, MUL_Y, MUL_Z, ACC_XY, ACC_Z, DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_p1x, r_p1y, r_p1z, r_p2x, r_p2y, r_p2z;
    logic [31:0] r_dx, r_dy, r_dz, r_sx, r_sy, r_sz, r_sxy, r_dist;
    logic        r_in_ack, r_out_stb, r_busy, r_coinc;
    logic        r_add_stb, r_mul_stb, r_add_z_ack, r_mul_z_ack;
    logic        r_wait_z, r_got_a, r_got_b;
    logic [31:0] w_add_a, w_add_b, w_mul_op, w_add_z, w_mul_z, w_z;
    logic        w_add_a_ack, w_add_b_ack, w_add_z_stb, w_mul_a_ack, w_mul_b_ack, w_mul_z_stb;
    logic        w_is_mul, w_next_add, w_next_mul, w_a_ack, w_b_ack, w_z_stb;

    sq_distance_fp_core #(.IS_MUL(1'b0)) u_add (
        .CLK(CLK), .RST(RST),
        .i_a(w_add_a), .i_a_stb(r_add_stb), .o_a_ack(w_add_a_ack),
        .i_b(w_add_b), .i_b_stb(r_add_stb), .o_b_ack(w_add_b_ack),
        .o_z(w_add_z), .o_z_stb(w_add_z_stb), .i_z_ack(r_add_z_ack)
    );

    sq_distance_fp_core #(.IS_MUL(1'b1)) u_mul (
        .CLK(CLK), .RST(RST),
        .i_a(w_mul_op), .i_a_stb(r_mul_stb), .o_a_ack(w_mul_a_ack),
        .i_b(w_mul_op), .i_b_stb(r_mul_stb), .o_b_ack(w_mul_b_ack),
        .o_z(w_mul_z), .o_z_stb(w_mul_z_stb), .i_z_ack(r_mul_z_ack)
    );

    // Operand routing and successor state for the current step.
    always_comb begin
        w_add_a    = 32'd0;
        w_add_b    = 32'd0;
        w_mul_op   = 32'd0;
        w_next     = IDLE;
        w_next_add = 1'b0;
        w_next_mul = 1'b0;
        case (r_state)
            SUB_X:   begin w_add_a = r_p2x; w_add_b = {~r_p1x[31], r_p1x[30:0]}; w_next = SUB_Y; w_next_add = 1'b1; end
            SUB_Y:   begin w_add_a = r_p2y; w_add_b = {~r_p1y[31], r_p1y[30:0]}; w_next = SUB_Z; w_next_add = 1'b1; end
            SUB_Z:   begin w_add_a = r_p2z; w_add_b = {~r_p1z[31], r_p1z[30:0]}; w_next = MUL_X; w_next_mul = 1'b1; end
            MUL_X:   begin w_mul_op = r_dx; w_next = MUL_Y; w_next_mul = 1'b1; end
            MUL_Y:   begin w_mul_op = r_dy; w_next = MUL_Z; w_next_mul = 1'b1; end
            MUL_Z:   begin w_mul_op = r_dz; w_next = ACC_XY; w_next_add = 1'b1; end
            ACC_XY:  begin w_add_a = r_sx; w_add_b = r_sy; w_next = ACC_Z; w_next_add = 1'b1; end
            ACC_Z:   begin w_add_a = r_sxy; w_add_b = r_sz; w_next = DONE; end
            default: begin w_next = IDLE; end
        endcase
    end

    assign w_is_mul = (r_state == MUL_X) || (r_state == MUL_Y) || (r_state == MUL_Z);
    assign w_a_ack  = w_is_mul ? w_mul_a_ack : w_add_a_ack;
    assign w_b_ack  = w_is_mul ? w_mul_b_ack : w_add_b_ack;
    assign w_z_stb  = w_is_mul ? w_mul_z_stb : w_add_z_stb;
    assign w_z      = w_is_mul ? w_mul_z : w_add_z;

    // Sequencer: accept, eight core operations, then hold the result until taken.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_p1x <= 32'd0; r_p1y <= 32'd0; r_p1z <= 32'd0;
            r_p2x <= 32'd0; r_p2y <= 32'd0; r_p2z <= 32'd0;
            r_dx  <= 32'd0; r_dy  <= 32'd0; r_dz  <= 32'd0;
            r_sx  <= 32'd0; r_sy  <= 32'd0; r_sz  <= 32'd0;
            r_sxy <= 32'd0; r_dist <= 32'd0;
            r_in_ack <= 1'b0; r_out_stb <= 1'b0; r_busy <= 1'b0; r_coinc <= 1'b0;
            r_add_stb <= 1'b0; r_mul_stb <= 1'b0; r_add_z_ack <= 1'b0; r_mul_z_ack <= 1'b0;
            r_wait_z <= 1'b0; r_got_a <= 1'b0; r_got_b <= 1'b0;
        end else begin
            r_in_ack    <= 1'b0;
            r_add_z_ack <= 1'b0;
            r_mul_z_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_stb) begin
                        r_p1x <= p1x; r_p1y <= p1y; r_p1z <= p1z;
                        r_p2x <= p2x; r_p2y <= p2y; r_p2z <= p2z;
                        r_in_ack  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_add_stb <= 1'b1;
                        r_wait_z  <= 1'b0;
                        r_state   <= SUB_X;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ack) begin
                        r_out_stb <= 1'b0;
                        r_busy    <= 1'b0;
                        r_coinc   <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    if (!r_wait_z) begin
                        if ((r_got_a || w_a_ack) && (r_got_b || w_b_ack)) begin
                            r_add_stb <= 1'b0;
                            r_mul_stb <= 1'b0;
                            r_got_a   <= 1'b0;
                            r_got_b   <= 1'b0;
                            r_wait_z  <= 1'b1;
                        end else begin
                            r_got_a <= r_got_a | w_a_ack;
                            r_got_b <= r_got_b | w_b_ack;
                        end
                    end else if (w_z_stb) begin
                        r_wait_z    <= 1'b0;
                        r_add_z_ack <= ~w_is_mul;
                        r_mul_z_ack <= w_is_mul;
                        r_add_stb   <= w_next_add;
                        r_mul_stb   <= w_next_mul;
                        r_state     <= w_next;
                        case (r_state)
                            SUB_X:  r_dx  <= w_z;
                            SUB_Y:  r_dy  <= w_z;
                            SUB_Z:  r_dz  <= w_z;
                            MUL_X:  r_sx  <= w_z;
                            MUL_Y:  r_sy  <= w_z;
                            MUL_Z:  r_sz  <= w_z;
                            ACC_XY: r_sxy <= w_z;
                            ACC_Z: begin
                                // A negative zero would fail the downstream sign test, so force it positive.
                                r_dist    <= (w_z[30:0] == 31'd0) ? 32'd0 : w_z;
                                r_coinc   <= (w_z[30:0] == 31'd0);
                                r_out_stb <= 1'b1;
                            end
                            default: r_sxy <= r_sxy;
                        endcase
                    end else begin
                        r_wait_z <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ack  = r_in_ack;
    assign dist_sq = r_dist;
    assign out_stb = r_out_stb;
    assign busy    = r_busy;
`ifdef SQ_DISTANCE_COINCIDENT_EN
    assign coincident = r_coinc;
`else
    logic w_unused_coinc;
    assign w_unused_coinc = r_coinc;
`endif
endmodule

// File: tb/tb_sq_distance.sv
// Scoreboard bench for sq_distance: stimulus pushes expected results, a monitor pops them on each out_stb/out_ack handshake.
module tb_sq_distance;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] p1x = 32'd0, p1y = 32'd0, p1z = 32'd0, p2x = 32'd0, p2y = 32'd0, p2z = 32'd0;
    logic        in_stb = 1'b0, out_ack = 1'b0;
    logic        in_ack, out_stb, busy;
    logic [31:0] dist_sq;
`ifdef SQ_DISTANCE_COINCIDENT_EN
    logic        coincident;
`endif

    localparam logic [31:0] F_0  = 32'h00000000, F_1  = 32'h3F800000, F_M1 = 32'hBF800000;
    localparam logic [31:0] F_3  = 32'h40400000, F_4  = 32'h40800000, F_15 = 32'h3FC00000;
    localparam logic [31:0] F_2  = 32'h40000000, F_M3 = 32'hC0400000;
    localparam logic [31:0] R_25 = 32'h41C80000, R_12 = 32'h41400000;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic        exp_c_q[$];
    logic        prev_stb = 1'b0;

    always #5 CLK = ~CLK;

    sq_distance dut (
        .CLK(CLK), .RST(RST),
        .p1x(p1x), .p1y(p1y), .p1z(p1z), .p2x(p2x), .p2y(p2y), .p2z(p2z),
        .in_stb(in_stb), .in_ack(in_ack), .dist_sq(dist_sq),
        .out_stb(out_stb), .out_ack(out_ack), .busy(busy)
`ifdef SQ_DISTANCE_COINCIDENT_EN
        , .coincident(coincident)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic expect_result(input logic [31:0] d, input logic c);
        exp_q.push_back(d);
        exp_c_q.push_back(c);
    endtask

    task automatic set_ops(input logic [31:0] ax, ay, az, bx, by, bz);
        p1x = ax; p1y = ay; p1z = az; p2x = bx; p2y = by; p2z = bz;
    endtask

    task automatic wait_in_ack();
        bit seen = 1'b0;
        for (int i = 0; (i < 20) && !seen; i++) begin
            @(negedge CLK);
            if (in_ack) seen = 1'b1;
        end
        check("in_ack_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic issue(input logic [31:0] ax, ay, az, bx, by, bz);
        @(posedge CLK); #1;
        set_ops(ax, ay, az, bx, by, bz);
        in_stb = 1'b1;
        wait_in_ack();
        in_stb = 1'b0;
    endtask

    task automatic wait_out();
        bit seen = 1'b0;
        for (int i = 0; (i < 200) && !seen; i++) begin
            @(negedge CLK);
            if (out_stb) seen = 1'b1;
        end
        check("out_stb_seen", {31'd0, seen}, 32'd1);
    endtask

    // Hold out_ack low for `hold` cycles, then complete the handshake; `poke` drives in_stb meanwhile.
    task automatic finish_out(input int hold, input bit poke);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            if (poke) in_stb = i[0];
            @(negedge CLK);
            check("hold_out_stb", {31'd0, out_stb}, 32'd1);
            check("hold_no_in_ack", {31'd0, in_ack}, 32'd0);
            if (exp_q.size() > 0) check("hold_dist_sq", dist_sq, exp_q[0]);
        end
        @(posedge CLK); #1;
        out_ack = 1'b1;
        if (poke) begin
            in_stb = 1'b1;
            expect_result(R_25, 1'b0);
        end
        @(posedge CLK); #1;
        out_ack = 1'b0;
        @(negedge CLK);
        check("post_out_stb", {31'd0, out_stb}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        if (poke) begin
            check("same_cycle_no_in_ack", {31'd0, in_ack}, 32'd0);
            @(negedge CLK);
            check("next_cycle_in_ack", {31'd0, in_ack}, 32'd1);
            in_stb = 1'b0;
            wait_out();
            finish_out(0, 1'b0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ack", {31'd0, in_ack}, 32'd0);
        check("rst_out_stb", {31'd0, out_stb}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dist_sq", dist_sq, 32'd0);
`ifdef SQ_DISTANCE_COINCIDENT_EN
        check("rst_coincident", {31'd0, coincident}, 32'd0);
`endif
    endtask

    // Monitor: any rising out_stb must be anticipated; each handshake consumes one expected result.
    always @(negedge CLK) begin
        logic [31:0] e;
        logic        c;
        if (RST && out_stb && !prev_stb) check("out_stb_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (RST && out_stb && out_ack && (exp_q.size() > 0)) begin
            e = exp_q.pop_front();
            c = exp_c_q.pop_front();
            check("dist_sq", dist_sq, e);
`ifdef SQ_DISTANCE_COINCIDENT_EN
            check("coincident", {31'd0, coincident}, {31'd0, c});
`else
            if (c === 1'bx) check("coincident_model", 32'd0, 32'd1);
`endif
        end
        prev_stb = out_stb;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before 500us");
        $fatal(1);
    end

    initial begin
        #2 RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs();
        @(posedge CLK); #1 RST = 1'b1;

        expect_result(R_25, 1'b0);
        issue(F_0, F_0, F_0, F_3, F_4, F_0);
        wait_out();
        finish_out(0, 1'b0);

        expect_result(R_12, 1'b0);
        issue(F_M1, F_M1, F_M1, F_1, F_1, F_1);
        wait_out();
        finish_out(0, 1'b0);

        expect_result(F_0, 1'b1);
        issue(F_15, F_2, F_M3, F_15, F_2, F_M3);
        wait_out();
        finish_out(0, 1'b0);

        expect_result(R_12, 1'b0);
        issue(F_M1, F_M1, F_M1, F_1, F_1, F_1);
        wait_out();
        set_ops(F_0, F_0, F_0, F_3, F_4, F_0);
        finish_out(10, 1'b1);

        issue(F_0, F_0, F_0, F_3, F_4, F_0);
        repeat (16) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs();
        @(posedge CLK); #1 RST = 1'b1;
        repeat (60) @(negedge CLK);
        check("abort_no_out_stb", {31'd0, out_stb}, 32'd0);

        expect_result(R_25, 1'b0);
        issue(F_0, F_0, F_0, F_3, F_4, F_0);
        wait_out();
        finish_out(0, 1'b0);

        expect_result(R_25, 1'b0);
        issue(F_0, F_0, F_0, F_3, F_4, F_0);
        set_ops(32'hDEADBEEF, 32'h7F800001, 32'hFF800000, 32'h12345678, 32'hCAFEF00D, 32'h7FC00000);
        wait_out();
        finish_out(0, 1'b0);

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sq_distance.md
SQ_DISTANCE -- requirements
Module: sq_distance

Interface
- REQ-001 The block SHALL expose the following ports, clock and reset first; one clock; RST is asynchronous and active-low.
  - CLK  in  1  single clock; all state changes on its rising edge.
  - RST  in  1  asynchronous, active-low reset.
  - p1x, p1y, p1z  in  32 each  sphere-1 centre, IEEE-754 single.
  - p2x, p2y, p2z  in  32 each  sphere-2 centre, IEEE-754 single.
  - in_stb  in  1  input operands valid.
  - in_ack  out  1  operands accepted, one-cycle pulse.
  - dist_sq  out  32  (p2-p1)·(p2-p1), IEEE-754 single; feeds the sqrt stage's n.
  - out_stb  out  1  dist_sq valid.
  - out_ack  in  1  consumer has taken dist_sq.
  - busy  out  1  high from acceptance until out_stb/out_ack handshake completes.
- REQ-002 The block SHALL have no parameters.

Function
- REQ-003 The block SHALL instantiate exactly one adder and one multiplier core (stb/ack handshake style) and time-share them; no other float arithmetic.
- REQ-004 FSM states SHALL be IDLE, SUB_X, SUB_Y, SUB_Z, MUL_X, MUL_Y, MUL_Z, ACC_XY, ACC_Z, DONE, traversed strictly in that order.
- REQ-005 IDLE: when in_stb=1, the block SHALL latch all six operands, pulse in_ack for one cycle, set busy, and enter SUB_X on the next cycle.
- REQ-006 SUB_x/y/z SHALL compute d = p2 + (-p1), negating by flipping bit 31 of the latched p1 component, and store d in an internal register.
- REQ-007 MUL_x/y/z SHALL compute d*d per axis into separate square registers sx, sy, sz.
- REQ-008 ACC_XY SHALL compute sx+sy; ACC_Z SHALL compute (sx+sy)+sz and load dist_sq.
- REQ-009 Each state SHALL assert the core's input strobes, wait for both input acks, then wait for output_z_stb, capture output_z, pulse output_z_ack for one cycle, then advance; latency SHALL equal the sum of 8 core operations plus 2 cycles (accept + DONE entry).
- REQ-010 DONE: out_stb SHALL be held high with dist_sq stable until out_ack=1; on that cycle the FSM SHALL return to IDLE, clearing out_stb and busy on the next edge.
- REQ-011 out_ack SHALL be ignored while out_stb=0; in_stb SHALL be ignored (no in_ack) in any state except IDLE.
- REQ-012 Operand inputs SHALL NOT be sampled after acceptance; input changes mid-operation SHALL have no effect on dist_sq.
- REQ-013 If in_stb=1 in the same cycle DONE completes its handshake, the new request SHALL be accepted no earlier than the following cycle (from IDLE).
- REQ-014 A -0.0 result SHALL be forced to +0.0 (bit 31 cleared) so the downstream sign test sees a non-negative value.
- REQ-015 NaN/Inf operands SHALL propagate through the cores unmodified; no exception flagging.

Reset
- REQ-016 While RST=0, the FSM SHALL enter IDLE; in_ack, out_stb and busy SHALL be 0; dist_sq and internal registers SHALL be 0x00000000.
- REQ-017 Reset asserted mid-operation SHALL abort the computation immediately, without producing out_stb.
- REQ-018 Core ack/strobe state SHALL be cleared by the same reset.
- REQ-019 After RST deasserts, the first accepted request SHALL compute correctly with no residual core state.

Configuration
- REQ-020 Macro SQ_DISTANCE_COINCIDENT_EN SHALL control an extra 1-bit output, coincident.
  - Defined: coincident SHALL be valid with out_stb and SHALL be 1 when dist_sq exponent and mantissa are all zero, else 0; reset value 0. This lets the downstream sqrt stage skip the n/x division for a zero n.
  - Undefined: the port and logic SHALL be absent.

Verification
- REQ-021 p1=(0,0,0), p2=(3.0,4.0,0) -> dist_sq=0x41C80000 (25.0), one out_stb.
- REQ-022 p1=(-1,-1,-1), p2=(1,1,1) -> dist_sq=0x41400000 (12.0).
- REQ-023 p1=p2=(1.5,2.0,-3.0) -> dist_sq=0x00000000; coincident=1 when SQ_DISTANCE_COINCIDENT_EN is defined.
- REQ-024 out_ack held low 10 cycles after out_stb -> dist_sq stable; in_stb pulses during the wait get no in_ack; then out_ack=1 -> idle next cycle.
- REQ-025 RST pulsed low during MUL_Y -> outputs at reset values, no out_stb; the next request (3,4,0) still yields 0x41C80000.
- REQ-026 Operands changed to garbage the cycle after in_ack -> result unchanged (0x41C80000 for the REQ-021 stimulus).
